// File: rtl/countdown_counter_pkg.sv
// Shared types and constants for the counter/timer subsystem.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/countdown_counter_if.sv
// Control inputs and status outputs of the down-counter, bundled as one port.
interface countdown_counter_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             start;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             tc;

  // Level-sampled strobes: there is no valid/ready handshake. The counter
  // samples en/start/load/load_val/auto_reload on every rising clk edge and
  // the driver is never back-pressured; outputs are valid every cycle.
  modport master (
    output en, start, load, load_val, auto_reload,
    input  count, busy, zero, tc
  );

  modport slave (
    input  en, start, load, load_val, auto_reload,
    output count, busy, zero, tc
  );

endinterface

// File: rtl/countdown_counter_dff_en.sv
// WIDTH-bit register with write enable and async active-low reset.
module dff_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_o <= RESET_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/countdown_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a
// one-cycle terminal-count pulse.
module countdown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH          = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD_DEFAULT = WIDTH'(8'hFF)
) (
  input  logic                 clk,
  input  logic                 rst,
  countdown_counter_if.slave   bus,
  output state_e               state_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q;
  logic             count_we, reload_we;
  logic             tc_q, tc_d;
  logic             terminal;

  // Terminal event: last enabled decrement while running.
  assign terminal = (state_q == RUN) && bus.en && (count_q == WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = (bus.load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start) state_d = (reload_q != '0) ? RUN : IDLE;
        RUN:  if (terminal && !bus.auto_reload) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: next count, reload capture and tc
  always_comb begin
    count_d   = count_q;
    count_we  = 1'b0;
    reload_we = 1'b0;
    tc_d      = 1'b0;
    if (bus.load) begin
      count_d   = bus.load_val;
      count_we  = 1'b1;
      reload_we = 1'b1;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        count_d  = reload_q;
        count_we = 1'b1;
      end
    end else if (bus.en) begin
      count_we = 1'b1;
      if (terminal) begin
        tc_d    = 1'b1;
        count_d = bus.auto_reload ? reload_q : '0;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  dff_en #(.WIDTH(WIDTH), .RESET_VAL('0)) u_count (
    .clk  (clk),
    .rst  (rst),
    .en_i (count_we),
    .d_i  (count_d),
    .q_o  (count_q)
  );

  dff_en #(.WIDTH(WIDTH), .RESET_VAL(RELOAD_DEFAULT)) u_reload (
    .clk  (clk),
    .rst  (rst),
    .en_i (reload_we),
    .d_i  (bus.load_val),
    .q_o  (reload_q)
  );

  // Outputs
  always_comb begin
    bus.count = count_q;
    bus.busy  = (state_q == RUN);
    bus.zero  = (count_q == '0);
    bus.tc    = tc_q;
    state_o   = state_q;
  end

endmodule

// File: tb/tb_countdown_counter.sv
// Directed-vector bench for countdown_counter with hand-computed expectations.
module tb_countdown_counter;
  import counter_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst;
  state_e state_o;

  countdown_counter_if #(.WIDTH(W)) bus ();

  countdown_counter #(.WIDTH(W), .RELOAD_DEFAULT(8'hFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_tc_q[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] exp_count,
                               input logic exp_busy, input logic exp_tc);
    check({tag, ".count"}, 32'(bus.count), 32'(exp_count));
    check({tag, ".busy"},  32'(bus.busy),  32'(exp_busy));
    check({tag, ".tc"},    32'(bus.tc),    32'(exp_tc));
    check({tag, ".zero"},  32'(bus.zero),  32'(exp_count == '0));
    check({tag, ".state"}, 32'(state_o == RUN), 32'(exp_busy));
  endtask

  // Driver: apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic ld, input logic [W-1:0] lv, input logic st,
                       input logic e, input logic ar);
    bus.load        = ld;
    bus.load_val    = lv;
    bus.start       = st;
    bus.en          = e;
    bus.auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] c;
    logic         t;
    logic [W-1:0] gate_exp[5];
    logic         gate_en[5];

    rst = 1'b0;
    bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;
    bus.en = 1'b0;   bus.auto_reload = 1'b0;
    #1;
    check_outputs("reset_init", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-count at count = 5, then start from RELOAD_DEFAULT
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    check_outputs("pre_reset", 8'd5, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check_outputs("async_reset", 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    check_outputs("start_default", 8'hFF, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("dec_fe", 8'hFE, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("dec_fd", 8'hFD, 1'b1, 1'b0);

    // One-shot from 3
    cycle(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    check_outputs("os_load", 8'd3, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("os_2", 8'd2, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("os_1", 8'd1, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("os_0_tc", 8'd0, 1'b0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("os_hold", 8'd0, 1'b0, 1'b0);

    // Auto-reload period 4 over 12 cycles
    exp_q    = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
    exp_tc_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cycle(1'b1, 8'd4, 1'b0, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      t = exp_tc_q.pop_front();
      check_outputs("auto_reload", c, 1'b1, t);
      if (exp_q.size() > 0) cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    end

    // Enable gating from 5
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    check_outputs("gate_load", 8'd5, 1'b1, 1'b0);
    gate_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    gate_exp = '{8'd4, 8'd4, 8'd4, 8'd3, 8'd2};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'd0, 1'b0, gate_en[i], 1'b0);
      check_outputs("gate", gate_exp[i], 1'b1, 1'b0);
    end

    // Load zero, start ignored, then load beats start/en
    cycle(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
    check_outputs("load_zero", 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    check_outputs("start_reload0", 8'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
    check_outputs("load_prio", 8'd7, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    check_outputs("start_in_run", 8'd6, 1'b1, 1'b0);

    // Count down to 1, then load on the terminal event
    for (int v = 5; v >= 1; v--) begin
      cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      check_outputs("to_one", W'(v), 1'b1, 1'b0);
    end
    cycle(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    check_outputs("load_on_tc", 8'd9, 1'b1, 1'b0);

    // Auto-reload with reload_reg = 1: tc every cycle
    cycle(1'b1, 8'd1, 1'b0, 1'b1, 1'b1);
    check_outputs("ar1_load", 8'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
      check_outputs("ar1_tc", 8'd1, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
